// File: rtl/dkongjr_wav_rom_port_pkg.sv
// Shared definitions for the wave-sample / sound-CPU ROM port.
//   DATA_W  : width of the external byte memory data bus
//   SILENCE : mid-scale sample value driven on the wave output after reset
//   state_e : access sequencer states (IDLE -> ACCESS -> LATCH -> IDLE)
package dkongjr_wav_rom_port_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] SILENCE = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LATCH  = 2'd2
    } state_e;

endpackage

// File: rtl/dkongjr_wav_rom_port_if.sv
// Client-side bus of the ROM port: the wave sound generator and the sound CPU.
//   I_WAV_AB  : wave sample address          O_WAV_DB  : last fetched wave byte
//   O_WAV_VLD : O_WAV_DB matches I_WAV_AB
//   I_CPU_REQ : CPU fetch request (level)    I_CPU_AB  : CPU fetch address
//   O_CPU_ACK : one-cycle acknowledge        O_CPU_DB  : CPU fetch data
// slave  : the port side (dkongjr_wav_rom_port)
// master : the client side (generator / CPU)
interface dkongjr_wav_rom_port_if #(
    parameter int unsigned ADDR_W = 19
);
    import dkongjr_wav_rom_port_pkg::*;

    logic [ADDR_W-1:0] I_WAV_AB;
    logic [DATA_W-1:0] O_WAV_DB;
    logic              O_WAV_VLD;
    logic              I_CPU_REQ;
    logic [ADDR_W-1:0] I_CPU_AB;
    logic              O_CPU_ACK;
    logic [DATA_W-1:0] O_CPU_DB;

    modport slave (
        input  I_WAV_AB, I_CPU_REQ, I_CPU_AB,
        output O_WAV_DB, O_WAV_VLD, O_CPU_ACK, O_CPU_DB
    );

    modport master (
        output I_WAV_AB, I_CPU_REQ, I_CPU_AB,
        input  O_WAV_DB, O_WAV_VLD, O_CPU_ACK, O_CPU_DB
    );

endinterface

// File: rtl/dkongjr_rom_arb.sv
// Grant selection between the sound CPU and the wave generator.
//   cpu_req   : CPU has a request to be served
//   wav_pend  : wave generator needs a fetch
//   last_cpu  : previous grant went to the CPU
//   grant_cpu : CPU owns the next access
//   grant_wav : wave generator owns the next access
// The CPU normally wins; after a CPU grant a pending wave fetch goes first so
// a CPU that keeps requesting cannot starve the sample stream.
module dkongjr_rom_arb (
    input  logic cpu_req,
    input  logic wav_pend,
    input  logic last_cpu,
    output logic grant_cpu,
    output logic grant_wav
);

    always_comb begin
        grant_cpu = cpu_req && !(last_cpu && wav_pend);
        grant_wav = wav_pend && !grant_cpu;
    end

endmodule

// File: rtl/dkongjr_wav_rom_port.sv
// Shares one external asynchronous byte memory between the wave sound
// generator and the sound CPU.
//   I_CLK, I_RST       : clock (rising edge) and synchronous active-high reset
//   bus (slave)        : wave and CPU client signals, see dkongjr_wav_rom_port_if
//   O_MEM_A            : memory address, held while O_MEM_CEn is high
//   O_MEM_CEn/O_MEM_OEn: active-low chip and output enables
//   I_MEM_D            : memory read data
// Each access: one IDLE cycle, max(WAIT_STATES,1) ACCESS cycles, one LATCH
// cycle; the data is captured on the LATCH exit edge.
module dkongjr_wav_rom_port
    import dkongjr_wav_rom_port_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 3,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    dkongjr_wav_rom_port_if.slave  bus,
    output logic [ADDR_W-1:0]      O_MEM_A,
    output logic                   O_MEM_CEn,
    output logic                   O_MEM_OEn,
    input  logic [DATA_W-1:0]      I_MEM_D
);

    localparam int unsigned WS_EFF = (WAIT_STATES == 0) ? 1 : WAIT_STATES;
    localparam int unsigned CNT_W  = $clog2(WS_EFF) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WS_EFF - 1);

    state_e            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              owner_cpu;
    logic              last_cpu;
    logic              wav_ok;
    logic [ADDR_W-1:0] wav_last_ab;
    logic [DATA_W-1:0] wav_db;
    logic [DATA_W-1:0] cpu_db;
    logic              cpu_ack;

    logic wav_pend;
    logic cpu_req_eff;
    logic grant_cpu;
    logic grant_wav;

    assign wav_pend = !wav_ok || (bus.I_WAV_AB != wav_last_ab);

    // During the ACK cycle the request line still carries the request just
    // answered; only a request still high one cycle later is a new one.
    assign cpu_req_eff = bus.I_CPU_REQ && !cpu_ack;

    dkongjr_rom_arb u_arb (
        .cpu_req   (cpu_req_eff),
        .wav_pend  (wav_pend),
        .last_cpu  (last_cpu),
        .grant_cpu (grant_cpu),
        .grant_wav (grant_wav)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            owner_cpu   <= 1'b0;
            last_cpu    <= 1'b0;
            wav_ok      <= 1'b0;
            wav_last_ab <= '0;
            wav_db      <= SILENCE;
            cpu_db      <= '0;
            cpu_ack     <= 1'b0;
            O_MEM_A     <= '0;
            O_MEM_CEn   <= 1'b1;
            O_MEM_OEn   <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu || grant_wav) begin
                        O_MEM_A   <= grant_cpu ? bus.I_CPU_AB : bus.I_WAV_AB;
                        O_MEM_CEn <= 1'b0;
                        O_MEM_OEn <= 1'b0;
                        owner_cpu <= grant_cpu;
                        last_cpu  <= grant_cpu;
                        wait_cnt  <= CNT_LOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state <= LATCH;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                LATCH: begin
                    if (owner_cpu) begin
                        cpu_db  <= I_MEM_D;
                        cpu_ack <= 1'b1;
                    end else begin
                        wav_db      <= I_MEM_D;
                        // O_MEM_A still holds the address this fetch used,
                        // even if the generator has moved on meanwhile.
                        wav_last_ab <= O_MEM_A;
                        wav_ok      <= 1'b1;
                    end
                    O_MEM_CEn <= 1'b1;
                    O_MEM_OEn <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    O_MEM_CEn <= 1'b1;
                    O_MEM_OEn <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.O_WAV_DB  = wav_db;
    assign bus.O_WAV_VLD = wav_ok && (bus.I_WAV_AB == wav_last_ab);
    assign bus.O_CPU_ACK = cpu_ack;
    assign bus.O_CPU_DB  = cpu_db;

endmodule
